// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2R/1W register file with clear sweep, dropped-write pulse and optional zero register.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ADDR_W-1:0] r_addr_a_i,
   input  logic [ADDR_W-1:0] r_addr_b_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic              write_reg_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic              clr_req_i,
   output logic [DATA_W-1:0] r_data_a_o,
   output logic [DATA_W-1:0] r_data_b_o,
   output logic              busy_o,
   output logic              clr_done_o,
   output logic              wr_drop_o
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              clr_done_q, wr_drop_q;
   logic              wr_ok, wr_drop_d;
   // A write lands only in IDLE, when no sweep is starting, and not on the hardwired zero entry.
   assign wr_ok = write_reg_i && state_q == IDLE && !clr_req_i && !(ZERO_REG != 0 && w_addr_i == '0);
   assign wr_drop_d = write_reg_i && !wr_ok;
`ifdef REGFILE_BYPASS_EN
   assign r_data_a_o = (ZERO_REG != 0 && r_addr_a_i == '0) ? '0 : (wr_ok && r_addr_a_i == w_addr_i) ? w_data_i : mem_q[r_addr_a_i];
   assign r_data_b_o = (ZERO_REG != 0 && r_addr_b_i == '0) ? '0 : (wr_ok && r_addr_b_i == w_addr_i) ? w_data_i : mem_q[r_addr_b_i];
`else
   assign r_data_a_o = (ZERO_REG != 0 && r_addr_a_i == '0) ? '0 : mem_q[r_addr_a_i];
   assign r_data_b_o = (ZERO_REG != 0 && r_addr_b_i == '0) ? '0 : mem_q[r_addr_b_i];
`endif
   assign busy_o     = state_q == CLEAR;
   assign clr_done_o = clr_done_q;
   assign wr_drop_o  = wr_drop_q;
   // Storage, clear sequencer and status pulses; reset wipes everything and aborts a sweep silently.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         wr_drop_q  <= wr_drop_d;
         clr_done_q <= 1'b0;
         if (wr_ok) mem_q[w_addr_i] <= w_data_i;
         if (state_q == IDLE) begin
            if (clr_req_i) begin
               state_q <= CLEAR;
               cnt_q   <= '0;
            end
         end else begin
            mem_q[cnt_q] <= '0;
            cnt_q        <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_q    <= IDLE;
               clr_done_q <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
   localparam int DW = 32, AW = 5, DEPTH = 32;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b0, we = 1'b0, clr = 1'b0;
   logic [AW-1:0] ra = '0, rb = '0, wa = '0;
   logic [DW-1:0] wd = '0;
   logic [DW-1:0] rda, rdb;
   logic busy, done, drop;
   regfile_mp dut (
      .clk_i(clk), .reset_i(reset), .r_addr_a_i(ra), .r_addr_b_i(rb), .w_addr_i(wa),
      .write_reg_i(we), .w_data_i(wd), .clr_req_i(clr), .r_data_a_o(rda), .r_data_b_o(rdb),
      .busy_o(busy), .clr_done_o(done), .wr_drop_o(drop));
   typedef struct {logic [DW-1:0] a, b; logic busy, done, drop;} exp_t;
   exp_t q[$];
   logic [DW-1:0] mem [DEPTH];
   int  pos = -1;
   bit  m_done = 0, m_drop = 0, valid_model = 0;
   int  n_chk = 0, n_fail = 0;
   function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && pos < 0 && !clr && a == wa) return wd;
`endif
      return mem[a];
   endfunction
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // reference model: applies the edge using the inputs as they stood at that edge
   task automatic model_edge();
      bit d;
      if (!reset) begin
         foreach (mem[i]) mem[i] = '0;
         pos = -1; m_done = 0; m_drop = 0; valid_model = 1;
      end else begin
         d = we && (pos >= 0 || clr || wa == 0);
         m_done = 0;
         if (pos >= 0) begin
            mem[pos] = '0;
            pos++;
            if (pos == DEPTH) begin pos = -1; m_done = 1; end
         end else if (clr) pos = 0;
         else if (we && wa != 0) mem[wa] = wd;
         m_drop = d;
      end
   endtask
   task automatic step(input bit r, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input bit w, input logic [AW-1:0] wadr, input logic [DW-1:0] wdat, input bit c);
      @(posedge clk);
      model_edge();
      #1;
      reset = r; ra = a; rb = b; we = w; wa = wadr; wd = wdat; clr = c;
      if (valid_model) q.push_back('{rd(ra), rd(rb), pos >= 0, m_done, m_drop});
   endtask
   task automatic rdp(input logic [AW-1:0] a, input logic [AW-1:0] b);
      step(1, a, b, 0, 0, 0, 0);
   endtask
   // monitor: compares every queued expectation against the outputs mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("r_data_a", rda, e.a);
            chk("r_data_b", rdb, e.b);
            chk("busy", DW'(busy), DW'(e.busy));
            chk("clr_done", DW'(done), DW'(e.done));
            chk("wr_drop", DW'(drop), DW'(e.drop));
         end
      end
   end
   initial begin
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      rdp(0, 1);
      rdp(31, 0);
      step(1, 0, 0, 1, 0, 32'hDEADBEEF, 0);
      rdp(0, 0);
      step(1, 0, 0, 1, 1, 32'h1, 0);
      step(1, 0, 0, 1, 2, 32'h2, 0);
      step(1, 0, 0, 1, 3, 32'h9, 0);
      rdp(3, 1);
      rdp(2, 2);
      step(1, 4, 0, 1, 4, 32'hB, 0);
      rdp(4, 0);
      for (int i = 1; i < DEPTH; i++) step(1, 5, 20, 1, AW'(i), 32'hA5A5A5A5, 0);
      step(1, 5, 20, 0, 0, 0, 1);
      for (int i = 0; i < 36; i++) begin
         if (i == 3) step(1, 7, 5, 1, 7, 32'h12345678, 0);
         else if (i == 6) step(1, 5, 20, 0, 0, 0, 1);
         else step(1, 5, 20, 0, 0, 0, 0);
      end
      for (int i = 0; i < DEPTH; i += 2) rdp(AW'(i), AW'(i + 1));
      step(1, 0, 0, 1, 9, 32'h5555AAAA, 1);
      for (int i = 0; i < 5; i++) rdp(9, 1);
      step(0, 9, 1, 0, 0, 0, 0);
      rdp(9, 1);
      step(1, 1, 0, 1, 1, 32'hCAFEF00D, 0);
      rdp(1, 9);
      rdp(1, 1);
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 199) != 0), AW'($urandom), AW'($urandom), $urandom_range(0, 2) != 0,
              AW'($urandom), $urandom, $urandom_range(0, 59) == 0);
      rdp(0, 0);
      repeat (4) @(negedge clk);
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file, the successor to the fixed 32x32 two-read/one-write register file used in the datapath experiments.
- Adds configurable data width and address width, an optional hardwired zero register, and a multi-cycle clear sequencer with busy and done status.
- Adds dropped-write reporting and optional write-to-read forwarding.
- Sits between instruction decode (read addresses) and writeback (write port) in the single-cycle and multi-cycle CPU experiments.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W (derived localparam).
- ZERO_REG, 1, when 1 entry 0 reads as 0 and writes to it are discarded.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- R_Addr_A  input  ADDR_W  read port A address.
- R_Addr_B  input  ADDR_W  read port B address.
- W_Addr  input  ADDR_W  write address.
- Write_Reg  input  1  write enable.
- W_Data  input  DATA_W  write data.
- Clr_Req  input  1  one-cycle request to start a clear sweep.
- R_Data_A  output  DATA_W  read data A (combinational).
- R_Data_B  output  DATA_W  read data B (combinational).
- Busy  output  1  clear sweep in progress.
- Clr_Done  output  1  one-cycle pulse when the sweep completes.
- Wr_Drop  output  1  registered pulse: a write was discarded the previous cycle.

Behaviour:
- Reset: Clk is the single clock. Reset is synchronous and active-low, sampled on the rising edge of Clk.
  - When Reset=0 at an edge: all DEPTH entries become 0, FSM goes to IDLE, Busy=0, Clr_Done=0, Wr_Drop=0, sweep counter=0.
  - Reset overrides every other input, including mid-sweep: the sweep is aborted with no Clr_Done pulse.
- Reads: combinational, zero latency. R_Data_x = mem[R_Addr_x]. If ZERO_REG=1 and the address is 0, R_Data_x = 0 regardless of storage.
- Writes, when Write_Reg=1 at an edge:
  - In IDLE: mem[W_Addr] <= W_Data, except W_Addr=0 with ZERO_REG=1.
  - The new value becomes visible on the read ports the cycle after the edge (without forwarding).
- Discarded writes:
  - A write is discarded if it targets address 0 with ZERO_REG=1, or if it occurs while the FSM is in CLEAR (including the cycle Clr_Req is accepted).
  - Wr_Drop = 1 for exactly one cycle after each discarded write.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: Clr_Req=1 at an edge. The counter loads 0 and Busy=1 from the next cycle.
  - CLEAR: each edge writes mem[cnt] <= 0 and increments cnt. Clr_Req is ignored; it does not restart the sweep.
  - CLEAR -> IDLE: on the edge that clears entry DEPTH-1. Busy=0 and Clr_Done=1 for one cycle after that edge.
  - A sweep takes exactly DEPTH cycles of Busy=1 (32 at defaults).
- Reads during CLEAR return the current stored contents: entries below cnt read 0, the rest keep old values.
- Clr_Req and Write_Reg together in IDLE: the write is discarded (Wr_Drop=1 next cycle) and the sweep starts.
- Counter wrap: cnt is ADDR_W bits. The terminal condition is cnt == DEPTH-1; no overflow is ever visible.
- W_Data is stored unmodified at full DATA_W; there is no width conversion.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If Write_Reg=1, the write is not discarded, and R_Addr_x == W_Addr, then R_Data_x = W_Data in the same cycle.
  - Zero-register masking still takes precedence.
  - No forwarding during CLEAR, since all writes are discarded then.
- Undefined: reads always return stored contents; a write is visible only from the next cycle.

Test Plan:
- Reset and zero register:
  - Hold Reset=0 one edge, release.
  - Read addresses 0, 1, 31 -> 0x00000000.
  - Write addr 0 data 0xDEADBEEF -> R_Data_A(addr 0)=0 and Wr_Drop=1 next cycle.
- Dual-port write/read:
  - Write 1=0x00000001, 2=0x00000002, 3=0x00000009 on successive edges.
  - Read A=3, B=1 -> 0x00000009 / 0x00000001.
  - Read A=2, B=2 -> both 0x00000002.
- Forwarding:
  - Write addr 4 data 0x0000000B with R_Addr_A=4 in the same cycle.
  - With REGFILE_BYPASS_EN: R_Data_A=0x0000000B in that cycle.
  - Without it: old value (0) that cycle, 0x0000000B the next cycle.
- Clear sweep:
  - Fill all 31 entries with 0xA5A5A5A5, pulse Clr_Req.
  - Busy high exactly 32 cycles; Clr_Done pulses once.
  - Mid-sweep (cycle 10) entry 5 reads 0 and entry 20 reads 0xA5A5A5A5.
  - After the sweep all entries read 0.
- Write and Clr_Req during sweep:
  - Issue Write_Reg=1 (addr 7, 0x12345678) while Busy -> Wr_Drop=1 next cycle; entry 7 reads 0 after the sweep.
  - Second Clr_Req while Busy -> sweep length unchanged (32 cycles).
- Reset mid-operation:
  - Start a sweep, assert Reset=0 at sweep cycle 5.
  - Next cycle: Busy=0, all entries 0, no Clr_Done pulse.
  - A new write to addr 1 afterwards succeeds.
